// File: rtl/dc_meter_pkg.sv
// -----------------------------------------------------------------------------
// dc_meter_pkg
// Shared types and helpers for the four-channel DC level meter.
//   state_e       : measurement FSM states (idle, settle, accumulate, done)
//   accWidth()    : accumulator width for a W-bit sample summed 2^LOG2_N times
//   tickCntWidth(): width of the shared tick counter for a given N and settle
//   DEFAULT_TICK_CNT_W : counter width for the default build (N=256, settle=4)
// No ports; imported by dc_meter and dc_meter_chan.
// -----------------------------------------------------------------------------
package dc_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Summing 2^log2n samples of w bits can grow by log2n bits, never more.
    function automatic int accWidth(input int w, input int log2n);
        return w + log2n;
    endfunction

    // The one counter must reach both N-1 (accumulate) and settle-1 (settle).
    function automatic int tickCntWidth(input int log2n, input int settle);
        int width;
        width = (log2n > 0) ? log2n : 1;
        if ($clog2(settle) > width) begin
            width = $clog2(settle);
        end
        return width;
    endfunction

    localparam int DEFAULT_TICK_CNT_W = tickCntWidth(8, 4);

endpackage

// File: rtl/dc_meter_chan.sv
// -----------------------------------------------------------------------------
// dc_meter_chan
// One measurement channel: signed accumulator, floor-mean shift, jack gating
// and (with DC_METER_RIPPLE_EN defined) running min/max for a ripple result.
// Ports:
//   clk, rst   : system clock, synchronous active-low reset
//   clear_i    : start of a measurement, empties the accumulator / min-max
//   accum_i    : accumulate sample_i this cycle
//   latch_i    : final accumulated sample, publish mean_o / ripple_o
//   jack_i     : channel plugged; unplugged channels publish zero
//   sample_i   : signed W-bit input sample
//   mean_o     : latched mean (signed W bits)
//   ripple_o   : latched peak-to-peak (unsigned W bits, 0 when feature off)
// Macro: DC_METER_RIPPLE_EN builds the min/max tracking.
// -----------------------------------------------------------------------------
module dc_meter_chan
    import dc_meter_pkg::*;
#(
    parameter int W      = 16,
    parameter int LOG2_N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         accum_i,
    input  logic         latch_i,
    input  logic         jack_i,
    input  logic [W-1:0] sample_i,
    output logic [W-1:0] mean_o,
    output logic [W-1:0] ripple_o
);

    localparam int ACC_W = accWidth(W, LOG2_N);

    logic signed [ACC_W-1:0] sampleExt;
    logic signed [ACC_W-1:0] accSum;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [W-1:0]     meanNext;
    logic        [W-1:0]     mean_q, mean_d;

    assign sampleExt = {{LOG2_N{sample_i[W-1]}}, sample_i};
    assign accSum    = acc_q + sampleExt;
    // The final sample is folded in combinationally so the mean is ready on
    // the same edge that takes the last sample; >>> floors toward -inf.
    assign meanNext  = W'(accSum >>> LOG2_N);

    // Accumulator and mean next-state: clear on start, add on every
    // accumulate strobe, publish the (jack-gated) mean on the final one.
    always_comb begin
        acc_d  = acc_q;
        mean_d = mean_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (accum_i) begin
            acc_d = accSum;
        end
        if (latch_i) begin
            mean_d = jack_i ? meanNext : '0;
        end
    end

    // Accumulator and mean registers, wiped by reset so an aborted
    // measurement leaves nothing behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q  <= '0;
            mean_q <= '0;
        end else begin
            acc_q  <= acc_d;
            mean_q <= mean_d;
        end
    end

    assign mean_o = mean_q;

`ifdef DC_METER_RIPPLE_EN
    logic signed [W-1:0] sampleS;
    logic signed [W-1:0] minNext, maxNext;
    logic signed [W-1:0] min_q, min_d, max_q, max_d;
    logic                first_q, first_d;
    logic        [W:0]   span;
    logic        [W-1:0] rippleNext;
    logic        [W-1:0] ripple_q, ripple_d;

    assign sampleS = sample_i;
    // The first accumulated sample seeds both extremes.
    assign minNext = (first_q || (sampleS < min_q)) ? sampleS : min_q;
    assign maxNext = (first_q || (sampleS > max_q)) ? sampleS : max_q;
    assign span    = {maxNext[W-1], maxNext} - {minNext[W-1], minNext};
    assign rippleNext = span[W] ? {W{1'b1}} : span[W-1:0];

    // Min/max tracking next-state: re-arm the seed on start, track on each
    // accumulate, publish the gated peak-to-peak on the final sample.
    always_comb begin
        min_d    = min_q;
        max_d    = max_q;
        first_d  = first_q;
        ripple_d = ripple_q;
        if (clear_i) begin
            first_d = 1'b1;
        end else if (accum_i) begin
            min_d   = minNext;
            max_d   = maxNext;
            first_d = 1'b0;
        end
        if (latch_i) begin
            ripple_d = jack_i ? rippleNext : '0;
        end
    end

    // Min/max and ripple registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            min_q    <= '0;
            max_q    <= '0;
            first_q  <= 1'b1;
            ripple_q <= '0;
        end else begin
            min_q    <= min_d;
            max_q    <= max_d;
            first_q  <= first_d;
            ripple_q <= ripple_d;
        end
    end

    assign ripple_o = ripple_q;
`else
    assign ripple_o = '0;
`endif

endmodule

// File: rtl/dc_meter.sv
// -----------------------------------------------------------------------------
// dc_meter
// Four-channel DC level meter. On meas_start it discards SETTLE sample ticks,
// then averages 2^LOG2_N ticks per channel and latches the means (and the
// peak-to-peak ripple when DC_METER_RIPPLE_EN is defined; else ripple = 0).
// Ports:
//   clk, rst            : system clock, synchronous active-low reset
//   sample_clk          : sample-rate level; each rising edge is one tick
//   sample_in0..3       : signed W-bit samples
//   sample_out0..3      : latched signed means
//   ripple0..3          : latched unsigned peak-to-peak
//   jack[7:0]           : bit k = input k plugged (bits 7:4 unused)
//   meas_start          : one-cycle start request
//   meas_busy/meas_done : handshake with the calibration controller
// Macro: DC_METER_RIPPLE_EN.
// -----------------------------------------------------------------------------
module dc_meter
    import dc_meter_pkg::*;
#(
    parameter int W      = 16,
    parameter int LOG2_N = 8,
    parameter int SETTLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_clk,
    input  logic [W-1:0] sample_in0,
    input  logic [W-1:0] sample_in1,
    input  logic [W-1:0] sample_in2,
    input  logic [W-1:0] sample_in3,
    output logic [W-1:0] sample_out0,
    output logic [W-1:0] sample_out1,
    output logic [W-1:0] sample_out2,
    output logic [W-1:0] sample_out3,
    input  logic [7:0]   jack,
    input  logic         meas_start,
    output logic         meas_busy,
    output logic         meas_done,
    output logic [W-1:0] ripple0,
    output logic [W-1:0] ripple1,
    output logic [W-1:0] ripple2,
    output logic [W-1:0] ripple3
);

    localparam int CW = tickCntWidth(LOG2_N, SETTLE);
    localparam logic [CW-1:0] N_LAST      = CW'((1 << LOG2_N) - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_e        START_STATE = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sclk_q;
    logic            tick;
    logic            clearStb, accumStb, latchStb;
    logic [W-1:0]    sampleIn [4];
    logic [W-1:0]    meanOut  [4];
    logic [W-1:0]    rippleOut[4];
    logic            unusedJack;

    assign tick       = sample_clk & ~sclk_q;
    assign unusedJack = ^jack[7:4];

    // Measurement sequencer: accepts a start only when idle or done, counts
    // settle ticks, then accumulate ticks, and fires the latch strobe on the
    // final tick so results and done appear on that same edge. A tick in the
    // accepting cycle is deliberately not counted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clearStb = 1'b0;
        accumStb = 1'b0;
        latchStb = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (meas_start) begin
                    clearStb = 1'b1;
                    cnt_d    = '0;
                    state_d  = START_STATE;
                end
            end
            ST_SETTLE: begin
                if (tick) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_ACCUM;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_ACCUM: begin
                if (tick) begin
                    accumStb = 1'b1;
                    if (cnt_q == N_LAST) begin
                        latchStb = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, tick counter and sample_clk edge-detect registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sample_clk;
        end
    end

    assign meas_busy = (state_q == ST_SETTLE) || (state_q == ST_ACCUM);
    assign meas_done = (state_q == ST_DONE);

    assign sampleIn[0] = sample_in0;
    assign sampleIn[1] = sample_in1;
    assign sampleIn[2] = sample_in2;
    assign sampleIn[3] = sample_in3;

    for (genvar k = 0; k < 4; k++) begin : gChan
        dc_meter_chan #(
            .W      (W),
            .LOG2_N (LOG2_N)
        ) uChan (
            .clk      (clk),
            .rst      (rst),
            .clear_i  (clearStb),
            .accum_i  (accumStb),
            .latch_i  (latchStb),
            .jack_i   (jack[k]),
            .sample_i (sampleIn[k]),
            .mean_o   (meanOut[k]),
            .ripple_o (rippleOut[k])
        );
    end

    assign sample_out0 = meanOut[0];
    assign sample_out1 = meanOut[1];
    assign sample_out2 = meanOut[2];
    assign sample_out3 = meanOut[3];
    assign ripple0     = rippleOut[0];
    assign ripple1     = rippleOut[1];
    assign ripple2     = rippleOut[2];
    assign ripple3     = rippleOut[3];

endmodule

// File: tb/tb_dc_meter.sv
// -----------------------------------------------------------------------------
// tb_dc_meter
// Directed bench for dc_meter (W=16, LOG2_N=8, SETTLE=4). Expected results are
// queued when a measurement is started and popped when done is observed.
// Ripple expectations follow DC_METER_RIPPLE_EN.
// -----------------------------------------------------------------------------
module tb_dc_meter;

    localparam int W      = 16;
    localparam int LOG2_N = 8;
    localparam int SETTLE = 4;
    localparam int N      = 1 << LOG2_N;
`ifdef DC_METER_RIPPLE_EN
    localparam bit RIP_ON = 1'b1;
`else
    localparam bit RIP_ON = 1'b0;
`endif

    typedef struct packed {
        logic [3:0][15:0] out;
        logic [3:0][15:0] rip;
    } result_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_clk = 1'b0;
    logic        meas_start = 1'b0;
    logic [7:0]  jack = 8'h0F;
    logic [15:0] sample_in0 = '0, sample_in1 = '0, sample_in2 = '0, sample_in3 = '0;
    logic [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
    logic [15:0] ripple0, ripple1, ripple2, ripple3;
    logic        meas_busy, meas_done;

    logic [15:0] obsOut[4];
    logic [15:0] obsRip[4];
    logic [15:0] valA[4], valB[4], valS[4];
    result_t     sbQ[$];
    result_t     lastRes = '0;
    int          checks  = 0;
    int          errors  = 0;

    dc_meter #(.W(W), .LOG2_N(LOG2_N), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_clk  (sample_clk),
        .sample_in0  (sample_in0),
        .sample_in1  (sample_in1),
        .sample_in2  (sample_in2),
        .sample_in3  (sample_in3),
        .sample_out0 (sample_out0),
        .sample_out1 (sample_out1),
        .sample_out2 (sample_out2),
        .sample_out3 (sample_out3),
        .jack        (jack),
        .meas_start  (meas_start),
        .meas_busy   (meas_busy),
        .meas_done   (meas_done),
        .ripple0     (ripple0),
        .ripple1     (ripple1),
        .ripple2     (ripple2),
        .ripple3     (ripple3)
    );

    assign obsOut[0] = sample_out0;
    assign obsOut[1] = sample_out1;
    assign obsOut[2] = sample_out2;
    assign obsOut[3] = sample_out3;
    assign obsRip[0] = ripple0;
    assign obsRip[1] = ripple1;
    assign obsRip[2] = ripple2;
    assign obsRip[3] = ripple3;

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] mk(input int v);
        logic [31:0] t;
        t = v;
        return t[15:0];
    endfunction

    function automatic result_t mkRes(input int o0, input int o1, input int o2, input int o3,
                                      input int r0, input int r1, input int r2, input int r3);
        result_t r;
        r.out[0] = mk(o0); r.out[1] = mk(o1); r.out[2] = mk(o2); r.out[3] = mk(o3);
        r.rip[0] = mk(r0); r.rip[1] = mk(r1); r.rip[2] = mk(r2); r.rip[3] = mk(r3);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input result_t r);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("%s_out%0d", tag, k), obsOut[k], r.out[k]);
            checkOutput($sformatf("%s_rip%0d", tag, k), obsRip[k], r.rip[k]);
        end
    endtask

    task automatic setPattern(input int s0, input int s1, input int s2, input int s3,
                              input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3);
        valS[0] = mk(s0); valS[1] = mk(s1); valS[2] = mk(s2); valS[3] = mk(s3);
        valA[0] = mk(a0); valA[1] = mk(a1); valA[2] = mk(a2); valA[3] = mk(a3);
        valB[0] = mk(b0); valB[1] = mk(b1); valB[2] = mk(b2); valB[3] = mk(b3);
    endtask

    // One sample tick: idle cycle, then sample_clk high with the data for
    // post-start tick number idx. Returns #1 after the consuming edge.
    task automatic applyStimulus(input int idx);
        logic [15:0] v[4];
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            if (idx < SETTLE) v[k] = valS[k];
            else if (((idx - SETTLE) % 2) == 0) v[k] = valA[k];
            else v[k] = valB[k];
        end
        sample_in0 = v[0]; sample_in1 = v[1]; sample_in2 = v[2]; sample_in3 = v[3];
        sample_clk = 1'b1;
        @(posedge clk); #1;
        sample_clk = 1'b0;
    endtask

    task automatic pulseReset(input string tag);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        checkOutput({tag, "_busy"}, {15'd0, meas_busy}, 16'd0);
        checkOutput({tag, "_done"}, {15'd0, meas_done}, 16'd0);
        checkAll(tag, '0);
    endtask

    task automatic runMeasurement(input string tag, input result_t exp, input int midStartAt,
                                  input bit startWithTick, input int abortAt);
        result_t prev;
        result_t got;
        prev = lastRes;
        sbQ.push_back(exp);
        @(posedge clk); #1;
        meas_start = 1'b1;
        if (startWithTick) begin
            sample_in0 = valS[0]; sample_in1 = valS[1]; sample_in2 = valS[2]; sample_in3 = valS[3];
            sample_clk = 1'b1;
        end
        @(posedge clk); #1;
        meas_start = 1'b0;
        sample_clk = 1'b0;
        checkOutput({tag, "_busyAfterStart"}, {15'd0, meas_busy}, 16'd1);
        checkOutput({tag, "_doneAfterStart"}, {15'd0, meas_done}, 16'd0);
        checkAll({tag, "_holdAfterStart"}, prev);
        for (int i = 0; i < SETTLE + N; i++) begin
            if (i == abortAt) begin
                pulseReset({tag, "_abort"});
                got = sbQ.pop_front();
                lastRes = '0;
                return;
            end
            if (i == midStartAt) begin
                @(posedge clk); #1 meas_start = 1'b1;
                @(posedge clk); #1 meas_start = 1'b0;
                checkOutput({tag, "_busyMidStart"}, {15'd0, meas_busy}, 16'd1);
            end
            if (i == SETTLE + N - 1) begin
                checkOutput({tag, "_doneEarly"}, {15'd0, meas_done}, 16'd0);
                checkAll({tag, "_holdBeforeEnd"}, prev);
            end
            applyStimulus(i);
        end
        checkOutput({tag, "_doneOnTime"}, {15'd0, meas_done}, 16'd1);
        checkOutput({tag, "_busyEnd"}, {15'd0, meas_busy}, 16'd0);
        checkOutput({tag, "_sbDepth"}, 16'(sbQ.size()), 16'd1);
        got = sbQ.pop_front();
        checkAll({tag, "_result"}, got);
        lastRes = exp;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        checkOutput("reset_busy", {15'd0, meas_busy}, 16'd0);
        checkOutput("reset_done", {15'd0, meas_done}, 16'd0);
        checkAll("reset", '0);

        $display("[TB] constant inputs, start coinciding with a tick");
        jack = 8'h0F;
        setPattern(30000, 30000, 30000, 30000,
                   4000, -4000, 0, 32767,
                   4000, -4000, 0, 32767);
        runMeasurement("const", mkRes(4000, -4000, 0, 32767, 0, 0, 0, 0), -1, 1'b1, -1);

        $display("[TB] flooring, start in DONE, start ignored mid-accumulate");
        setPattern(0, 0, 0, 0,
                   1, -1, -32768, 0,
                   2, -2, -32768, 0);
        runMeasurement("floor", mkRes(1, -2, -32768, 0, RIP_ON ? 1 : 0, RIP_ON ? 1 : 0, 0, 0),
                       SETTLE + 100, 1'b0, -1);

        $display("[TB] jack gating");
        jack = 8'h0D;
        setPattern(0, 0, 0, 0,
                   500, 1234, -7, 0,
                   500, 1234, -7, 0);
        runMeasurement("jack", mkRes(500, 0, -7, 0, 0, 0, 0, 0), -1, 1'b0, -1);

        $display("[TB] ripple");
        jack = 8'h0F;
        setPattern(0, 0, 0, 0,
                   100, 0, 0, 0,
                   -100, 0, 0, 0);
        runMeasurement("ripple", mkRes(0, 0, 0, 0, RIP_ON ? 200 : 0, 0, 0, 0), -1, 1'b0, -1);

        $display("[TB] settle discard");
        setPattern(30000, 30000, 30000, 30000,
                   10, 10, 10, 10,
                   10, 10, 10, 10);
        runMeasurement("settle", mkRes(10, 10, 10, 10, 0, 0, 0, 0), -1, 1'b0, -1);

        $display("[TB] reset mid-accumulate");
        setPattern(0, 0, 0, 0,
                   777, 777, 777, 777,
                   777, 777, 777, 777);
        runMeasurement("abort", mkRes(777, 777, 777, 777, 0, 0, 0, 0), -1, 1'b0, SETTLE + 100);

        $display("[TB] fresh measurement after abort");
        setPattern(0, 0, 0, 0,
                   -555, 321, 9, -32768,
                   -555, 321, 9, -32768);
        runMeasurement("fresh", mkRes(-555, 321, 9, -32768, 0, 0, 0, 0), -1, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dc_meter.md
# dc_meter

Four-channel DC level meter core, the measurement-side counterpart to cores that drive fixed calibration voltages onto the outputs. On request it discards a few settling samples, then averages a power-of-two number of samples per input channel and latches the means. It sits in the core slot with the standard four-in/four-out sample interface, plus a start/busy/done handshake for the calibration controller.

## Interface
- W, 16, sample width (signed two's complement)
- LOG2_N, 8, log2 of the number of averaged samples (N = 256)
- SETTLE, 4, number of sample ticks discarded after start (0 allowed)

- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-low reset
- sample_clk  in  1  sample-rate level signal, synchronous to clk; each rising edge is one sample tick
- sample_in0..3  in  W signed  input samples
- sample_out0..3  out  W signed  latched mean of the corresponding channel
- jack  in  8  jack-detect; bit k (k=0..3) = input k plugged
- meas_start  in  1  one-cycle start request
- meas_busy  out  1  measurement in progress
- meas_done  out  1  results valid; held until next accepted start
- ripple0..3  out  W unsigned  peak-to-peak (max-min) over the averaged window

## Operation
- Tick detection: sclk_q <= sample_clk; tick = sample_clk & ~sclk_q. Samples are taken from sample_in* on the tick cycle only.
- States: IDLE, SETTLE, ACCUM, DONE.
  - IDLE/DONE + meas_start: accept. Clear the counter and accumulators, drop done, and go to SETTLE (ACCUM if SETTLE==0).
  - SETTLE: count ticks; after the SETTLE-th tick, go to ACCUM. Samples are ignored.
  - ACCUM: on each tick, acc_k += sample_in_k. After the N-th tick, go to DONE.
  - meas_start in SETTLE/ACCUM is ignored. meas_start and a tick in the same cycle in IDLE: the start is accepted and that tick is not counted.
- Accumulator width is W+LOG2_N signed; overflow is impossible. Mean = (acc + final sample) >>> LOG2_N, an arithmetic shift that floors toward negative infinity, truncated to W bits (always in range).
- Jack: if jack[k]==0 at the final tick, sample_out_k and ripple_k latch 0.
- sample_out* and ripple* change only when entering DONE; otherwise they hold their previous results.
- meas_busy = state is SETTLE or ACCUM. meas_done = state is DONE.

## Timing
- Reset (rst==0 at a clk edge): state IDLE, sclk_q=0, counters and accumulators 0, sample_out*=0, ripple*=0, meas_busy=0, meas_done=0. This applies mid-measurement too; no partial result is latched.
- Start accepted at edge t: meas_busy=1 after edge t.
- Results, meas_done=1 and meas_busy=0 all update on the same edge that samples the final ACCUM tick. There is zero extra latency.
- Total duration is SETTLE+N ticks after acceptance.
- The input sample is registered on the tick cycle itself; there is no sample_clk phase dependence beyond edge detection.

## Configuration
- DC_METER_RIPPLE_EN defined: each channel tracks running signed min/max during ACCUM (initialised from the first accumulated sample). At DONE, ripple_k = max-min, computed in W+1 bits and saturated to 2^W-1.
- Not defined: no min/max logic is built; ripple0..3 are tied to 0. The ports remain, so the interface is identical.

## Structure
- dc_meter_pkg: state enum (IDLE, SETTLE, ACCUM, DONE); ACC_W = W+LOG2_N helper function; tick-counter width constant.
- Sub-module dc_meter_chan: per-channel accumulator, mean shift, jack gating and optional min/max. It is instantiated 4x and driven by shared clear/accumulate/latch strobes from the dc_meter FSM.

## Test plan
- Constant inputs: in0=4000, in1=-4000, in2=0, in3=32767, jack=0x0F, LOG2_N=8 -> out0=4000, out1=-4000, out2=0, out3=32767; ripple all 0; done asserted exactly SETTLE+256 ticks after start.
- Flooring: in0 alternating 1,2 -> out0=1. in1 alternating -1,-2 -> out1=-2. in2 all -32768 -> out2=-32768 with no overflow.
- Jack gating: jack=0x0D, in1=1234 -> out1=0, others correct. Ripple with macro on: in0 alternating 100,-100 -> ripple0=200; with macro off -> ripple0=0.
- Handshake: meas_start pulsed at mid-ACCUM -> ignored, with the same completion tick. Start in DONE -> done drops next cycle and the old outputs hold until the new DONE.
- Settle discard: SETTLE=4, first 4 post-start ticks carry 30000 and the rest carry 10 -> out0=10.
- Reset mid-ACCUM -> all outputs 0, busy=0, done=0. A subsequent start gives a correct fresh result with no residue from the aborted accumulation.
